// File: rtl/pong_match_controller.sv
// Match sequencer for pong: serve delay, rally, point award, win detection and
// game-over hold, paced by frame ticks taken from the rising edge of VSync.
module pong_match_controller #(
  parameter int c_GAME_WINDOW_WIDTH  = 40,
  parameter int c_PADDLE_HEIGHT      = 6,
  parameter int c_SCORE_LIMIT        = 9,
  parameter int c_SERVE_DELAY_FRAMES = 60,
  parameter int c_POINT_HOLD_FRAMES  = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_VSync,
  input  logic       i_StartGame,
  input  logic [5:0] i_Ball_X_Pos,
  input  logic [5:0] i_Ball_Y_Pos,
  input  logic [5:0] i_Paddle1_Y_Pos,
  input  logic [5:0] i_Paddle2_Y_Pos,
  output logic       o_GameRunning,
  output logic       o_BallReset,
  output logic       o_ServeDir,
  output logic [3:0] o_P1_ScoreCount,
  output logic [3:0] o_P2_ScoreCount,
  output logic       o_GameOver,
  output logic [1:0] o_Winner,
  output logic       o_FlashOn,
  output logic [2:0] o_State
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SERVE     = 3'd1;
  localparam logic [2:0] RUNNING   = 3'd2;
  localparam logic [2:0] POINT     = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam logic [5:0] c_RIGHT_COL  = 6'(c_GAME_WINDOW_WIDTH - 1);
  localparam logic [6:0] c_PAD_H      = 7'(c_PADDLE_HEIGHT);
  localparam logic [3:0] c_LIMIT      = 4'(c_SCORE_LIMIT);
  localparam logic [7:0] c_SERVE_LAST = 8'(c_SERVE_DELAY_FRAMES - 1);
  localparam logic [7:0] c_HOLD_LAST  = 8'(c_POINT_HOLD_FRAMES - 1);

  logic [2:0] r_State;
  logic       r_VSync_Prev;
  logic       r_Start_Prev;
  logic [7:0] r_FrameCnt;
  logic [3:0] r_P1_Score;
  logic [3:0] r_P2_Score;
  logic       r_ServeDir;
  logic [1:0] r_Winner;

  logic       w_Tick;
  logic       w_Start_Rise;
  logic [6:0] w_Ball_Y;
  logic [6:0] w_P1_Top;
  logic [6:0] w_P2_Top;
  logic       w_P1_Hit;
  logic       w_P2_Hit;
  logic       w_P2_Scores;
  logic       w_P1_Scores;

  assign w_Tick       = i_VSync & ~r_VSync_Prev;
  assign w_Start_Rise = i_StartGame & ~r_Start_Prev;

  // Hit windows are widened to 7 bits so a paddle near the bottom cannot wrap
  assign w_Ball_Y = {1'b0, i_Ball_Y_Pos};
  assign w_P1_Top = {1'b0, i_Paddle1_Y_Pos};
  assign w_P2_Top = {1'b0, i_Paddle2_Y_Pos};
  assign w_P1_Hit = (w_Ball_Y >= w_P1_Top) && (w_Ball_Y < (w_P1_Top + c_PAD_H));
  assign w_P2_Hit = (w_Ball_Y >= w_P2_Top) && (w_Ball_Y < (w_P2_Top + c_PAD_H));

  assign w_P2_Scores = (i_Ball_X_Pos == 6'd0) && !w_P1_Hit;
  assign w_P1_Scores = (i_Ball_X_Pos == c_RIGHT_COL) && !w_P2_Hit;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State      <= IDLE;
      r_VSync_Prev <= 1'b0;
      r_Start_Prev <= 1'b0;
      r_FrameCnt   <= 8'd0;
      r_P1_Score   <= 4'd0;
      r_P2_Score   <= 4'd0;
      r_ServeDir   <= 1'b1;
      r_Winner     <= 2'b00;
    end else begin
      r_VSync_Prev <= i_VSync;
      r_Start_Prev <= i_StartGame;
      case (r_State)
        IDLE: begin
          if (i_StartGame) begin
            r_State    <= SERVE;
            r_FrameCnt <= 8'd0;
          end
        end
        SERVE: begin
          if (w_Tick) begin
            if (r_FrameCnt == c_SERVE_LAST) begin
              r_State    <= RUNNING;
              r_FrameCnt <= 8'd0;
            end else begin
              r_FrameCnt <= r_FrameCnt + 8'd1;
            end
          end
        end
        RUNNING: begin
          // A miss on the left wins priority should both ever coincide
          if (w_P2_Scores) begin
            if (r_P2_Score < c_LIMIT) r_P2_Score <= r_P2_Score + 4'd1;
            r_ServeDir <= 1'b0;
            r_State    <= POINT;
            r_FrameCnt <= 8'd0;
          end else if (w_P1_Scores) begin
            if (r_P1_Score < c_LIMIT) r_P1_Score <= r_P1_Score + 4'd1;
            r_ServeDir <= 1'b1;
            r_State    <= POINT;
            r_FrameCnt <= 8'd0;
          end
        end
        POINT: begin
          if (w_Tick) begin
            if (r_FrameCnt == c_HOLD_LAST) begin
              r_FrameCnt <= 8'd0;
              if (r_P1_Score == c_LIMIT) begin
                r_Winner <= 2'b01;
                r_State  <= GAME_OVER;
              end else if (r_P2_Score == c_LIMIT) begin
                r_Winner <= 2'b10;
                r_State  <= GAME_OVER;
              end else begin
                r_State <= SERVE;
              end
            end else begin
              r_FrameCnt <= r_FrameCnt + 8'd1;
            end
          end
        end
        GAME_OVER: begin
          // Only a fresh press restarts; a level left high from the last match is ignored
          if (w_Start_Rise) begin
            r_P1_Score <= 4'd0;
            r_P2_Score <= 4'd0;
            r_Winner   <= 2'b00;
            r_ServeDir <= 1'b1;
            r_State    <= SERVE;
            r_FrameCnt <= 8'd0;
          end else if (w_Tick) begin
            r_FrameCnt <= r_FrameCnt + 8'd1;
          end
        end
        default: begin
          r_State    <= IDLE;
          r_FrameCnt <= 8'd0;
        end
      endcase
    end
  end

  assign o_State         = r_State;
  assign o_GameRunning   = (r_State == RUNNING);
  assign o_BallReset     = (r_State != RUNNING);
  assign o_GameOver      = (r_State == GAME_OVER);
  assign o_ServeDir      = r_ServeDir;
  assign o_P1_ScoreCount = r_P1_Score;
  assign o_P2_ScoreCount = r_P2_Score;
  assign o_Winner        = r_Winner;
  assign o_FlashOn       = (r_State == POINT)     ? r_FrameCnt[2] :
                           (r_State == GAME_OVER) ? r_FrameCnt[3] : 1'b0;

endmodule

// File: tb/tb_pong_match_controller.sv
// Scoreboard bench for pong_match_controller: directed match scenarios push
// expected output values; a negedge monitor pops and compares them.
module tb_pong_match_controller;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_VSync;
  logic       i_StartGame;
  logic [5:0] i_Ball_X_Pos;
  logic [5:0] i_Ball_Y_Pos;
  logic [5:0] i_Paddle1_Y_Pos;
  logic [5:0] i_Paddle2_Y_Pos;
  logic       o_GameRunning;
  logic       o_BallReset;
  logic       o_ServeDir;
  logic [3:0] o_P1_ScoreCount;
  logic [3:0] o_P2_ScoreCount;
  logic       o_GameOver;
  logic [1:0] o_Winner;
  logic       o_FlashOn;
  logic [2:0] o_State;

  localparam int F_STATE   = 0;
  localparam int F_RUNNING = 1;
  localparam int F_BALLRST = 2;
  localparam int F_SERVDIR = 3;
  localparam int F_P1      = 4;
  localparam int F_P2      = 5;
  localparam int F_GAMEOVR = 6;
  localparam int F_WINNER  = 7;
  localparam int F_FLASH   = 8;

  typedef struct {
    string name;
    int    field;
    int    value;
  } expect_t;

  expect_t scoreQ[$];
  int compareCount = 0;
  int mismatchCount = 0;

  pong_match_controller dut (
    .i_Clk           (i_Clk),
    .i_Rst_L         (i_Rst_L),
    .i_VSync         (i_VSync),
    .i_StartGame     (i_StartGame),
    .i_Ball_X_Pos    (i_Ball_X_Pos),
    .i_Ball_Y_Pos    (i_Ball_Y_Pos),
    .i_Paddle1_Y_Pos (i_Paddle1_Y_Pos),
    .i_Paddle2_Y_Pos (i_Paddle2_Y_Pos),
    .o_GameRunning   (o_GameRunning),
    .o_BallReset     (o_BallReset),
    .o_ServeDir      (o_ServeDir),
    .o_P1_ScoreCount (o_P1_ScoreCount),
    .o_P2_ScoreCount (o_P2_ScoreCount),
    .o_GameOver      (o_GameOver),
    .o_Winner        (o_Winner),
    .o_FlashOn       (o_FlashOn),
    .o_State         (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic int getActual(input int field);
    case (field)
      F_STATE:   return int'(o_State);
      F_RUNNING: return int'(o_GameRunning);
      F_BALLRST: return int'(o_BallReset);
      F_SERVDIR: return int'(o_ServeDir);
      F_P1:      return int'(o_P1_ScoreCount);
      F_P2:      return int'(o_P2_ScoreCount);
      F_GAMEOVR: return int'(o_GameOver);
      F_WINNER:  return int'(o_Winner);
      F_FLASH:   return int'(o_FlashOn);
      default:   return -1;
    endcase
  endfunction

  // Monitor: drains every queued expectation at the falling edge
  initial begin
    expect_t e;
    int actual;
    forever begin
      @(negedge i_Clk);
      while (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        actual = getActual(e.field);
        compareCount++;
        if (actual != e.value) begin
          mismatchCount++;
          $display("[TB] FAIL %s: got %0d, expected %0d", e.name, actual, e.value);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int field, input int value);
    expect_t e;
    e.name  = name;
    e.field = field;
    e.value = value;
    scoreQ.push_back(e);
  endtask

  task automatic applyStimulus(input int bx, input int by, input int p1, input int p2);
    i_Ball_X_Pos    = 6'(bx);
    i_Ball_Y_Pos    = 6'(by);
    i_Paddle1_Y_Pos = 6'(p1);
    i_Paddle2_Y_Pos = 6'(p2);
  endtask

  task automatic stepClocks(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic frameTicks(input int n);
    repeat (n) begin
      i_VSync = 1'b1;
      stepClocks(1);
      i_VSync = 1'b0;
      stepClocks(1);
    end
  endtask

  task automatic holdVSync(input int clocks);
    i_VSync = 1'b1;
    stepClocks(clocks);
    i_VSync = 1'b0;
    stepClocks(1);
  endtask

  task automatic centreBall();
    applyStimulus(20, 15, 10, 20);
  endtask

  initial begin
    int sides[8] = '{1, 1, 1, 2, 2, 2, 2, 2};
    i_Rst_L     = 1'b0;
    i_VSync     = 1'b0;
    i_StartGame = 1'b0;
    centreBall();
    stepClocks(3);
    i_Rst_L = 1'b1;
    stepClocks(1);
    checkOutput("rst_state", F_STATE, 0);
    checkOutput("rst_ballreset", F_BALLRST, 1);
    checkOutput("rst_running", F_RUNNING, 0);
    checkOutput("rst_servedir", F_SERVDIR, 1);
    checkOutput("rst_p1", F_P1, 0);
    checkOutput("rst_p2", F_P2, 0);
    checkOutput("rst_winner", F_WINNER, 0);
    checkOutput("rst_gameover", F_GAMEOVR, 0);
    checkOutput("rst_flash", F_FLASH, 0);

    frameTicks(5);
    checkOutput("idle_ignores_ticks", F_STATE, 0);

    i_StartGame = 1'b1;
    stepClocks(1);
    i_StartGame = 1'b0;
    checkOutput("start_to_serve", F_STATE, 1);
    checkOutput("serve_ballreset", F_BALLRST, 1);

    // 58 ticks plus one long VSync level = 59 ticks, still serving
    frameTicks(58);
    holdVSync(20);
    checkOutput("serve_vsync_level_one_tick", F_STATE, 1);
    frameTicks(1);
    checkOutput("serve_to_running", F_STATE, 2);
    checkOutput("running_gamerunning", F_RUNNING, 1);
    checkOutput("running_ballreset", F_BALLRST, 0);

    applyStimulus(0, 10, 10, 20);
    stepClocks(1);
    checkOutput("p1_window_top_hit", F_STATE, 2);
    applyStimulus(0, 15, 10, 20);
    stepClocks(1);
    checkOutput("p1_window_bottom_hit", F_STATE, 2);
    applyStimulus(0, 12, 10, 20);
    stepClocks(1);
    checkOutput("p1_window_mid_hit", F_P2, 0);
    applyStimulus(0, 16, 10, 20);
    stepClocks(1);
    centreBall();
    checkOutput("p2_point_score", F_P2, 1);
    checkOutput("p2_point_servedir", F_SERVDIR, 0);
    checkOutput("p2_point_state", F_STATE, 3);
    checkOutput("point_running", F_RUNNING, 0);
    checkOutput("point_flash_start", F_FLASH, 0);

    frameTicks(4);
    checkOutput("point_flash_on", F_FLASH, 1);
    frameTicks(4);
    checkOutput("point_flash_off", F_FLASH, 0);
    frameTicks(21);
    checkOutput("point_hold_29", F_STATE, 3);
    frameTicks(1);
    checkOutput("point_hold_30_serve", F_STATE, 1);

    frameTicks(60);
    checkOutput("second_serve_running", F_STATE, 2);
    applyStimulus(39, 25, 10, 20);
    stepClocks(1);
    checkOutput("p2_window_bottom_hit", F_P1, 0);
    applyStimulus(39, 5, 10, 20);
    stepClocks(1);
    centreBall();
    checkOutput("p1_point_score", F_P1, 1);
    checkOutput("p1_point_servedir", F_SERVDIR, 1);
    checkOutput("p1_point_state", F_STATE, 3);

    for (int k = 2; k <= 9; k++) begin
      frameTicks(30);
      frameTicks(60);
      applyStimulus(39, 5, 10, 20);
      stepClocks(1);
      centreBall();
      checkOutput($sformatf("p1_run_score_%0d", k), F_P1, k);
    end

    // Start pressed during POINT is ignored and then stays high into GAME_OVER
    i_StartGame = 1'b1;
    frameTicks(29);
    checkOutput("final_point_hold", F_STATE, 3);
    frameTicks(1);
    checkOutput("gameover_state", F_STATE, 4);
    checkOutput("gameover_flag", F_GAMEOVR, 1);
    checkOutput("gameover_winner", F_WINNER, 1);
    checkOutput("gameover_p1", F_P1, 9);
    checkOutput("gameover_p2", F_P2, 1);
    checkOutput("gameover_ballreset", F_BALLRST, 1);
    stepClocks(5);
    checkOutput("start_held_no_restart", F_STATE, 4);
    i_StartGame = 1'b0;
    stepClocks(2);
    frameTicks(8);
    checkOutput("gameover_flash", F_FLASH, 1);
    checkOutput("gameover_still", F_STATE, 4);
    i_StartGame = 1'b1;
    stepClocks(1);
    i_StartGame = 1'b0;
    checkOutput("restart_state", F_STATE, 1);
    checkOutput("restart_p1", F_P1, 0);
    checkOutput("restart_p2", F_P2, 0);
    checkOutput("restart_winner", F_WINNER, 0);
    checkOutput("restart_servedir", F_SERVDIR, 1);
    checkOutput("restart_gameover", F_GAMEOVR, 0);

    foreach (sides[i]) begin
      frameTicks(60);
      if (sides[i] == 1) applyStimulus(39, 5, 10, 20);
      else               applyStimulus(0, 16, 10, 20);
      stepClocks(1);
      centreBall();
      frameTicks(30);
    end
    frameTicks(60);
    checkOutput("mid_match_state", F_STATE, 2);
    checkOutput("mid_match_p1", F_P1, 3);
    checkOutput("mid_match_p2", F_P2, 5);
    checkOutput("mid_match_servedir", F_SERVDIR, 0);

    i_Rst_L = 1'b0;
    stepClocks(1);
    i_Rst_L = 1'b1;
    checkOutput("midrst_state", F_STATE, 0);
    checkOutput("midrst_p1", F_P1, 0);
    checkOutput("midrst_p2", F_P2, 0);
    checkOutput("midrst_winner", F_WINNER, 0);
    checkOutput("midrst_ballreset", F_BALLRST, 1);
    checkOutput("midrst_servedir", F_SERVDIR, 1);
    checkOutput("midrst_running", F_RUNNING, 0);

    stepClocks(2);
    if (scoreQ.size() != 0) begin
      mismatchCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", scoreQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
